fu_issue_ctrl: RTL and testbench

- Issue/collect controller that drives the functional_unit operand and instruction inputs and captures its Z/FLAGS results.
- Sits between an upstream op source (valid/ready request channel) and functional_unit, and returns tagged results on a valid/ready response channel.
- Credit accounting means a result is never dropped, even when the response sink stalls.

---
 rtl/fu_pkg.sv | 36 +++
 rtl/fu_result_fifo.sv | 74 +++++++
 rtl/fu_result_fifo_chk.sv | 18 +
 rtl/fu_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_fu_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_pkg.sv
// Shared widths and transaction types for functional_unit, its issue controller and benches.
// Also carries the modulo pointer increment used by the result FIFO.
package fu_pkg;

    localparam int FU_DATA_W = 32;
    localparam int FU_INST_W = 5;
    localparam int FU_FLAG_W = 4;
    localparam int FU_TAG_W  = 4;

    typedef struct packed {
        logic [FU_DATA_W-1:0] z;
        logic [FU_FLAG_W-1:0] flags;
        logic [FU_TAG_W-1:0]  tag;
    } fu_result_t;

    typedef struct packed {
        logic [FU_DATA_W-1:0] a;
        logic [FU_DATA_W-1:0] b;
        logic [FU_DATA_W-1:0] c;
        logic [FU_INST_W-1:0] inst;
        logic                 ci;
        logic [FU_TAG_W-1:0]  tag;
    } fu_req_t;

    // Wraps at an arbitrary depth so non-power-of-2 FIFOs work.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
        logic [31:0] nxt;
        if (ptr == depth - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// First-word-fall-through result FIFO with arbitrary depth and occupancy count.
// A write into an empty FIFO becomes visible on the following cycle (no bypass).
module fu_result_fifo import fu_pkg::*; #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage and write pointer; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= PTR_W'(wrap_inc(32'(r_wr_ptr), 32'(DEPTH)));
        end
    end

    // Read pointer and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= PTR_W'(wrap_inc(32'(r_rd_ptr), 32'(DEPTH)));
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fu_result_fifo_chk u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_push),
        .i_pop   (i_pop),
        .i_full  (o_full),
        .i_empty (o_empty)
    );

endmodule

// File: rtl/fu_result_fifo_chk.sv
// Protocol checker for fu_result_fifo: no overflow, no underflow.
module fu_result_fifo_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_push,
    input logic i_pop,
    input logic i_full,
    input logic i_empty
);

    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && i_full && !i_pop));

    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_pop && i_empty));

endmodule

// File: rtl/fu_issue_ctrl.sv
// Issue/collect controller for functional_unit: registers operands into the FU, tracks
// in-flight ops by tag, and queues results with credit so none is ever dropped.
module fu_issue_ctrl import fu_pkg::*; #(
    parameter int DATA_W     = FU_DATA_W,
    parameter int INST_W     = FU_INST_W,
    parameter int FLAG_W     = FU_FLAG_W,
    parameter int TAG_W      = FU_TAG_W,
    parameter int FU_LATENCY = 1,
    parameter int RES_DEPTH  = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [DATA_W-1:0] i_req_a,
    input  logic [DATA_W-1:0] i_req_b,
    input  logic [DATA_W-1:0] i_req_c,
    input  logic [INST_W-1:0] i_req_inst,
    input  logic              i_req_ci,
    input  logic [TAG_W-1:0]  i_req_tag,
    output logic [DATA_W-1:0] o_fu_a,
    output logic [DATA_W-1:0] o_fu_b,
    output logic [DATA_W-1:0] o_fu_c,
    output logic [INST_W-1:0] o_fu_inst,
    output logic              o_fu_ci,
    input  logic [DATA_W-1:0] i_fu_z,
    input  logic [FLAG_W-1:0] i_fu_flags,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_z,
    output logic [FLAG_W-1:0] o_rsp_flags,
    output logic [TAG_W-1:0]  o_rsp_tag,
    output logic              o_busy
);

    localparam int STAGES = FU_LATENCY + 1;
    localparam int RES_W  = DATA_W + FLAG_W + TAG_W;
    localparam int CNT_W  = $clog2(RES_DEPTH + 1);
    localparam int IF_W   = $clog2(STAGES + 1);

    logic [DATA_W-1:0] r_fu_a;
    logic [DATA_W-1:0] r_fu_b;
    logic [DATA_W-1:0] r_fu_c;
    logic [INST_W-1:0] r_fu_inst;
    logic              r_fu_ci;
    logic [STAGES-1:0] r_pipe_vld;
    logic [TAG_W-1:0]  r_pipe_tag [STAGES];
    logic [IF_W-1:0]   r_inflight_cnt;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_fifo_cnt;
    logic [31:0]       w_used;
    logic [RES_W-1:0]  w_wdata;
    logic [RES_W-1:0]  w_rdata;

    // Credit uses registered counts only, so a same-cycle pop frees a slot one cycle later.
    assign w_used      = 32'(w_fifo_cnt) + 32'(r_inflight_cnt);
    assign o_req_ready = !w_full && (w_used < 32'(RES_DEPTH));
    assign w_accept    = i_req_valid && o_req_ready;

    assign w_push  = r_pipe_vld[STAGES-1];
    assign w_wdata = {i_fu_z, i_fu_flags, r_pipe_tag[STAGES-1]};
    assign w_pop   = o_rsp_valid && i_rsp_ready;

    assign o_fu_a    = r_fu_a;
    assign o_fu_b    = r_fu_b;
    assign o_fu_c    = r_fu_c;
    assign o_fu_inst = r_fu_inst;
    assign o_fu_ci   = r_fu_ci;

    assign o_rsp_valid = !w_empty;
    assign {o_rsp_z, o_rsp_flags, o_rsp_tag} = w_rdata;
    assign o_busy = (r_inflight_cnt != {IF_W{1'b0}}) || !w_empty;

    // Operand registers driving the FU; they change only on an accepted request.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fu_a    <= {DATA_W{1'b0}};
            r_fu_b    <= {DATA_W{1'b0}};
            r_fu_c    <= {DATA_W{1'b0}};
            r_fu_inst <= {INST_W{1'b0}};
            r_fu_ci   <= 1'b0;
        end else if (w_accept) begin
            r_fu_a    <= i_req_a;
            r_fu_b    <= i_req_b;
            r_fu_c    <= i_req_c;
            r_fu_inst <= i_req_inst;
            r_fu_ci   <= i_req_ci;
        end
    end

    // Stage 0 lines up with operands at the FU inputs; the last stage lines up with Z/FLAGS.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pipe_vld <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                r_pipe_tag[i] <= {TAG_W{1'b0}};
            end
        end else begin
            r_pipe_vld    <= {r_pipe_vld[STAGES-2:0], w_accept};
            r_pipe_tag[0] <= i_req_tag;
            for (int i = 1; i < STAGES; i++) begin
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    // In-flight occupancy: +1 on accept, -1 when the last stage lands in the FIFO.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_inflight_cnt <= {IF_W{1'b0}};
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight_cnt <= r_inflight_cnt + IF_W'(1);
                2'b01:   r_inflight_cnt <= r_inflight_cnt - IF_W'(1);
                default: r_inflight_cnt <= r_inflight_cnt;
            endcase
        end
    end

    fu_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (i_clock),
        .i_rst_n (i_reset_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Directed bench for fu_issue_ctrl with a stub FU (Z = A ^ B, FLAGS = INST[3:0], one cycle).
module tb_fu_issue_ctrl;
    import fu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic [4:0]  req_inst;
    logic        req_ci;
    logic [3:0]  req_tag;
    logic [31:0] fu_a, fu_b, fu_c;
    logic [4:0]  fu_inst;
    logic        fu_ci;
    logic [31:0] fu_z;
    logic [3:0]  fu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic [3:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        fu_z     <= fu_a ^ fu_b;
        fu_flags <= fu_inst[3:0];
    end

    fu_issue_ctrl #(.FU_LATENCY(1), .RES_DEPTH(4)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_c(req_c),
        .i_req_inst(req_inst), .i_req_ci(req_ci), .i_req_tag(req_tag),
        .o_fu_a(fu_a), .o_fu_b(fu_b), .o_fu_c(fu_c), .o_fu_inst(fu_inst), .o_fu_ci(fu_ci),
        .i_fu_z(fu_z), .i_fu_flags(fu_flags),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_z(rsp_z), .o_rsp_flags(rsp_flags), .o_rsp_tag(rsp_tag),
        .o_busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [4:0] inst, input logic ci, input logic [3:0] tag);
        req_valid = 1'b1;
        req_a = a; req_b = b; req_c = c;
        req_inst = inst; req_ci = ci; req_tag = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = 32'd0; req_b = 32'd0; req_c = 32'd0;
        req_inst = 5'd0; req_ci = 1'b0; req_tag = 4'd0;
        step(); step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (fu_a !== 32'd0 || fu_inst !== 5'd0 || fu_ci !== 1'b0) begin failures++; $display("FAIL reset_fu got a=%0h inst=%0h ci=%0h exp=0", fu_a, fu_inst, fu_ci); end
        checks++; if (rsp_z !== 32'd0 || rsp_flags !== 4'd0 || rsp_tag !== 4'd0) begin failures++; $display("FAIL reset_rsp_data got z=%0h f=%0h t=%0h exp=0", rsp_z, rsp_flags, rsp_tag); end
        rst_n = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0h exp=1", req_ready); end
    endtask

    task automatic test_single_op();
        rsp_ready = 1'b0;
        drive_op(32'h0000_00F0, 32'h0000_000F, 32'h1234_5678, 5'h03, 1'b1, 4'd3);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0h exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (fu_a !== 32'h0000_00F0 || fu_b !== 32'h0000_000F) begin failures++; $display("FAIL single_fu_ab got a=%0h b=%0h exp a=f0 b=f", fu_a, fu_b); end
        checks++; if (fu_c !== 32'h1234_5678 || fu_inst !== 5'h03 || fu_ci !== 1'b1) begin failures++; $display("FAIL single_fu_cic got c=%0h inst=%0h ci=%0h exp 12345678/3/1", fu_c, fu_inst, fu_ci); end
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL single_after_accept got busy=%0h valid=%0h exp 1/0", busy, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0h exp=0", rsp_valid); end
        checks++; if (fu_a !== 32'h0000_00F0) begin failures++; $display("FAIL single_fu_hold got=%0h exp=f0", fu_a); end
        step();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", rsp_valid); end
        checks++; if (rsp_z !== 32'h0000_00FF || rsp_flags !== 4'h3 || rsp_tag !== 4'd3) begin failures++; $display("FAIL single_data got z=%0h f=%0h t=%0h exp ff/3/3", rsp_z, rsp_flags, rsp_tag); end
        rsp_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_drained got valid=%0h busy=%0h exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int s = 0; s < 11; s++) begin
            if (s < 8) begin
                drive_op(32'h0000_1000 + 32'(s), 32'hA5A5_0000, 32'd0, 5'(16 + s), 1'b0, 4'(s));
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready s=%0d got=%0h exp=1", s, req_ready); end
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (s >= 2 && s < 10) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_tag !== 4'(s - 2) || rsp_z !== 32'hA5A5_1000 + 32'(s - 2) || rsp_flags !== 4'(s - 2)) begin
                    failures++;
                    $display("FAIL b2b_rsp s=%0d got v=%0h t=%0h z=%0h f=%0h exp tag=%0d", s, rsp_valid, rsp_tag, rsp_z, rsp_flags, s - 2);
                end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle s=%0d got=%0h exp=0", s, rsp_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        int  n_acc = 0;
        logic acc;
        rsp_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            drive_op(32'h0000_0200 + 32'(n_acc), 32'hFFFF_0000, 32'd0, 5'(n_acc), 1'b0, 4'(n_acc));
            acc = req_ready;
            step();
            if (acc) n_acc++;
        end
        checks++; if (n_acc !== 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", n_acc); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%0h exp=0", req_ready); end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || rsp_z !== 32'hFFFF_0200 || rsp_flags !== 4'd0) begin
                failures++; $display("FAIL bp_stable s=%0d got v=%0h t=%0h z=%0h exp 1/0/ffff0200", s, rsp_valid, rsp_tag, rsp_z);
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'(k) || rsp_z !== 32'hFFFF_0200 + 32'(k) || rsp_flags !== 4'(k)) begin
                failures++; $display("FAIL bp_drain k=%0d got v=%0h t=%0h z=%0h exp tag=%0d", k, rsp_valid, rsp_tag, rsp_z, k);
            end
            step();
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back k=%0d got=%0h exp=1", k, req_ready); end
        end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_empty got v=%0h busy=%0h exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_full_pushpop();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(32'h0000_3000 + 32'(i), 32'd0, 32'd0, 5'(i + 4), 1'b0, 4'(10 + i));
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL fpp_ready i=%0d got=%0h exp=1", i, req_ready); end
            step();
        end
        req_valid = 1'b0;
        step();
        checks++; if (req_ready !== 1'b0 || rsp_tag !== 4'd10) begin failures++; $display("FAIL fpp_credit got ready=%0h tag=%0h exp 0/a", req_ready, rsp_tag); end
        rsp_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'(10 + i) || rsp_z !== 32'h0000_3000 + 32'(i) || rsp_flags !== 4'(i + 4)) begin
                failures++; $display("FAIL fpp_order i=%0d got v=%0h t=%0h z=%0h f=%0h exp tag=%0d", i, rsp_valid, rsp_tag, rsp_z, rsp_flags, 10 + i);
            end
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL fpp_ready_after i=%0d got=%0h exp=1", i, req_ready); end
        end
        step();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fpp_empty got v=%0h busy=%0h exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(32'h0000_5000 + 32'(i), 32'd1, 32'd0, 5'd1, 1'b0, 4'(i));
            step();
        end
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_async got v=%0h busy=%0h exp 0/0", rsp_valid, busy); end
        step(); step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_stale s=%0d got v=%0h busy=%0h exp 0/0", s, rsp_valid, busy); end
        end
        drive_op(32'h0000_0009, 32'h0000_0090, 32'd0, 5'h0C, 1'b0, 4'd9);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0h exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        step(); step();
        checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd9 || rsp_z !== 32'h0000_0099 || rsp_flags !== 4'hC) begin failures++; $display("FAIL rstmid_newop got v=%0h t=%0h z=%0h f=%0h exp 1/9/99/c", rsp_valid, rsp_tag, rsp_z, rsp_flags); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_soak();
        fu_result_t exp_q[$];
        fu_result_t exp_r;
        fu_result_t new_r;
        int   n_acc = 0;
        int   n_pop = 0;
        int   cyc   = 0;
        logic acc, pop;
        while ((n_acc < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            if (n_acc < 1000 && $urandom_range(0, 3) != 0) begin
                drive_op($urandom(), $urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end else begin
                req_valid = 1'b0;
            end
            rsp_ready = (n_acc >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            acc = req_valid && req_ready;
            pop = rsp_valid && rsp_ready;
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL soak_extra cyc=%0d got tag=%0h exp no response", cyc, rsp_tag);
                end else begin
                    exp_r = exp_q.pop_front();
                    n_pop++;
                    if ({rsp_z, rsp_flags, rsp_tag} !== exp_r) begin
                        failures++; $display("FAIL soak_data cyc=%0d got z=%0h f=%0h t=%0h exp z=%0h f=%0h t=%0h", cyc, rsp_z, rsp_flags, rsp_tag, exp_r.z, exp_r.flags, exp_r.tag);
                    end
                end
            end
            if (acc) begin
                new_r.z = req_a ^ req_b;
                new_r.flags = req_inst[3:0];
                new_r.tag = req_tag;
                exp_q.push_back(new_r);
                n_acc++;
            end
            step();
            cyc++;
        end
        req_valid = 1'b0;
        checks++; if (cyc >= 20000) begin failures++; $display("FAIL soak_timeout got cycles=%0d exp <20000", cyc); end
        checks++; if (n_pop !== 1000) begin failures++; $display("FAIL soak_count got pops=%0d exp 1000", n_pop); end
        step();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL soak_idle got v=%0h busy=%0h exp 0/0", rsp_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure();
        test_full_pushpop();
        test_reset_mid();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
